// File: rtl/inst_fetch_mod.sv
// ============================================================================
//  Module   : inst_fetch_mod
//  Brief    : Byte-wide instruction fetch unit with optional CB-prefix
//             (two-byte opcode) assembly. Optional feature macro:
//             INST_FETCH_CB_PREFIX_EN enables the PREFIX state.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_mod #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        adv,
    input  logic        load_pc,
    input  logic [15:0] new_pc,
    input  logic [7:0]  mem_data,
    input  logic        mem_ack,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    output logic [8:0]  inst_buffer,
    output logic        inst_valid,
    output logic [15:0] pc_out
);

`ifdef INST_FETCH_CB_PREFIX_EN
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_PREFIX = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    localparam logic [7:0] C_PREFIX_OP = 8'hCB;

    logic [8:0]  ibuf_q;
    logic [8:0]  ibuf_d;
`else
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_READY = 1'b1
    } state_t;

    logic [7:0]  ibuf_q;
    logic [7:0]  ibuf_d;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] pc_inc;

    assign pc_inc = pc_q + 16'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ibuf_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ibuf_q  <= ibuf_d;
        end
    end

    // A redirect wins over everything else and discards any data in flight.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ibuf_d  = ibuf_q;
        if (load_pc) begin
            pc_d    = new_pc;
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ack) begin
                        pc_d = pc_inc;
`ifdef INST_FETCH_CB_PREFIX_EN
                        if (mem_data == C_PREFIX_OP) begin
                            state_d = ST_PREFIX;
                        end else begin
                            ibuf_d  = {1'b0, mem_data};
                            state_d = ST_READY;
                        end
`else
                        ibuf_d  = mem_data;
                        state_d = ST_READY;
`endif
                    end
                end
`ifdef INST_FETCH_CB_PREFIX_EN
                ST_PREFIX: begin
                    if (mem_ack) begin
                        pc_d    = pc_inc;
                        ibuf_d  = {1'b1, mem_data};
                        state_d = ST_READY;
                    end
                end
`endif
                ST_READY: begin
                    if (adv) begin
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    assign mem_rd     = (state_q != ST_READY);
    assign inst_valid = (state_q == ST_READY);
    assign mem_addr   = pc_q;
    assign pc_out     = pc_q;

`ifdef INST_FETCH_CB_PREFIX_EN
    assign inst_buffer = ibuf_q;
`else
    assign inst_buffer = {1'b0, ibuf_q};
`endif

endmodule

`default_nettype wire
